// File: rtl/serdes_loopback_channel_if.sv
// serdes_loopback_channel_if
//   Bundles the transmit-side block bus, the receive-side block bus and the
//   channel control/status signals of the SerDes loopback channel.
//   master : the PHY/test side. It drives tx_data, tx_hdr, bitslip, link_up,
//            err_inject and err_bit, and observes rx_data, rx_hdr and the status.
//   slave  : the channel model. It consumes the tx side and controls, and
//            produces rx_data, rx_hdr, slip_offset, bitslip_events and err_count.
//   Valid/ready: none. One block moves per clock in each direction,
//   unconditionally. The link_up signal is the only qualifier. While it is
//   low the receive side carries the invalid header 2'b00.
interface serdes_loopback_channel_if #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic [HDR_WIDTH-1:0]  tx_hdr;
  logic                  bitslip;
  logic                  link_up;
  logic                  err_inject;
  logic [6:0]            err_bit;
  logic [DATA_WIDTH-1:0] rx_data;
  logic [HDR_WIDTH-1:0]  rx_hdr;
  logic [6:0]            slip_offset;
  logic [15:0]           bitslip_events;
  logic [15:0]           err_count;

  modport master (
    output tx_data, tx_hdr, bitslip, link_up, err_inject, err_bit,
    input  rx_data, rx_hdr, slip_offset, bitslip_events, err_count
  );

  modport slave (
    input  tx_data, tx_hdr, bitslip, link_up, err_inject, err_bit,
    output rx_data, rx_hdr, slip_offset, bitslip_events, err_count
  );
endinterface

// File: rtl/serdes_loopback_channel.sv
// serdes_loopback_channel
//   Loopback channel model between the PHY transmit and receive SerDes ports.
//   Each 66-bit block {data, hdr} passes through a two-block window. The window
//   emulates a deserializer that is misaligned by slip_offset bits. Each rising
//   edge on bitslip moves the window by one bit, modulo 66. Single-bit error
//   injection and a forced link-down are also supported.
// Ports
//   clk_tb     : shared tx/rx clock, rising edge
//   rx_rst_tb  : asynchronous, active-high reset
//   ch (slave) : tx_data/tx_hdr in; bitslip, link_up, err_inject, err_bit in;
//                rx_data/rx_hdr out; slip_offset, bitslip_events, err_count out
module serdes_loopback_channel #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2,
  parameter int INIT_SLIP  = 0
) (
  input  logic                     clk_tb,
  input  logic                     rx_rst_tb,
  serdes_loopback_channel_if.slave ch
);

  localparam int         BW       = DATA_WIDTH + HDR_WIDTH;
  localparam logic [6:0] LAST_OFF = 7'(BW - 1);
  localparam logic [6:0] BW_IDX   = 7'(BW);
  localparam logic [6:0] INIT_OFF = 7'(INIT_SLIP);

  logic [BW-1:0]   cur_q;
  logic [BW-1:0]   out_q;
  logic [BW-1:0]   blk;
  logic [BW-1:0]   sel;
  logic [BW-1:0]   flip_mask;
  logic [2*BW-1:0] win;
  logic [7:0]      win_idx;
  logic            bitslip_q;
  logic            slip_rise;
  logic            flip_en;
  logic [6:0]      slip_q;
  logic [15:0]     bev_q;
  logic [15:0]     ecnt_q;

  always_comb begin
    // The header is bit 0..1, so it is the first bit on the wire. The older
    // block sits in the low half of the window, and offset 0 selects it whole.
    blk       = {ch.tx_data, ch.tx_hdr};
    win       = {blk, cur_q};
    win_idx   = {1'b0, slip_q};
    sel       = win[win_idx +: BW];
    // A flip is counted only when it really lands on the output. Out-of-range
    // indices and link-down cycles apply no flip.
    flip_en   = ch.link_up & ch.err_inject & (ch.err_bit < BW_IDX);
    flip_mask = '0;
    if (flip_en) flip_mask[ch.err_bit] = 1'b1;
    slip_rise = ch.bitslip & ~bitslip_q;
  end

  always_ff @(posedge clk_tb or posedge rx_rst_tb) begin
    if (rx_rst_tb) begin
      cur_q     <= '0;
      out_q     <= '0;
      bitslip_q <= 1'b0;
      slip_q    <= INIT_OFF;
      bev_q     <= '0;
      ecnt_q    <= '0;
    end else begin
      // cur_q keeps tracking the line during link-down, so the window is
      // already primed when the link comes back.
      cur_q     <= blk;
      out_q     <= ch.link_up ? (sel ^ flip_mask) : '0;
      bitslip_q <= ch.bitslip;
      // The new offset takes effect from the next output load, because this
      // edge's output uses the old slip_q.
      if (slip_rise) begin
        slip_q <= (slip_q == LAST_OFF) ? 7'd0 : slip_q + 7'd1;
        if (bev_q != 16'hFFFF) bev_q <= bev_q + 16'd1;
      end
      if (flip_en && (ecnt_q != 16'hFFFF)) ecnt_q <= ecnt_q + 16'd1;
    end
  end

  assign ch.rx_hdr         = out_q[HDR_WIDTH-1:0];
  assign ch.rx_data        = out_q[BW-1:HDR_WIDTH];
  assign ch.slip_offset    = slip_q;
  assign ch.bitslip_events = bev_q;
  assign ch.err_count      = ecnt_q;

endmodule

// File: doc/serdes_loopback_channel.md
# serdes_loopback_channel

Behavioural-synthesizable SerDes channel model between the 10G PHY transmit SerDes interface and its receive SerDes interface. It accepts 66-bit blocks (64-bit data plus 2-bit sync header) and presents them to the PHY receiver through a configurable bit-offset window. The window emulates an unaligned deserializer: it moves one bit per `bitslip` request, supports single-bit error injection, and can force a link-down condition. It replaces the plain register loopback so block-lock acquisition, BER and error counting can be exercised.

## Interface
- `DATA_WIDTH`, 64, data bits per block
- `HDR_WIDTH`, 2, sync header bits per block
- `INIT_SLIP`, 0, bit offset after reset; legal range 0..65
- `clk_tb` input 1: shared tx/rx clock, rising edge.
- `rx_rst_tb` input 1: reset, asynchronous, active-high.
- `tx_data` input 64: PHY `serdes_tx_data`.
- `tx_hdr` input 2: PHY `serdes_tx_hdr`.
- `bitslip` input 1: PHY `serdes_rx_bitslip` request.
- `link_up` input 1: when 0, the channel carries no valid blocks.
- `err_inject` input 1: one-cycle request to flip one output bit.
- `err_bit` input 7: index (0..65) of the bit to flip.
- `rx_data` output 64: to PHY `serdes_rx_data`.
- `rx_hdr` output 2: to PHY `serdes_rx_hdr`.
- `slip_offset` output 7: current window offset.
- `bitslip_events` output 16: saturating count of accepted bitslips.
- `err_count` output 16: saturating count of applied injections.

## Operation
- **Block bit order.** Block B = {tx_data, tx_hdr}. B[1:0] = header and is transmitted first. B[65:2] = data, LSB first.
- **Previous-block register.** `cur_q` (66 bits) captures B every cycle.
- **Window.** W = {B, cur_q}, 132 bits, with the older block in the low bits.
- **Selected block.** S = W[slip_offset +: 66]. With offset 0, S = cur_q.
- **Output register.** On each edge, out = S, with bit `err_bit` inverted when `err_inject`=1 and `err_bit`<66.
  - rx_hdr = out[1:0].
  - rx_data = out[65:2].
- **Link down.** When `link_up`=0, the output register loads rx_hdr=2'b00 (invalid header) and rx_data=0.
  - Error injection is ignored while `link_up`=0.
  - `cur_q` keeps updating while `link_up`=0.
- **Bitslip detection.**
  - `bitslip_q` registers `bitslip`.
  - A rising edge (bitslip=1, bitslip_q=0) advances slip_offset by 1 modulo 66 (65 → 0).
  - The same rising edge increments bitslip_events, saturating at 16'hFFFF.
  - A level held high counts once.
- **Error count.** err_count increments, saturating, only when a flip is actually applied.
- **No handshake.** The channel accepts and emits one block per cycle unconditionally.

## Timing
- **Reset values.** While `rx_rst_tb` is high, all of the following hold immediately (asynchronously), independent of clk_tb:
  - rx_data=0, rx_hdr=2'b00, cur_q=0, bitslip_q=0
  - slip_offset=INIT_SLIP
  - bitslip_events=0, err_count=0
- **Latency.** A block presented before edge k appears on rx_* after edge k+1 at offset 0.
  - At offset n>0, the output after edge k+1 holds bits n..65 of the block presented before edge k, followed by bits 0..n-1 of the block presented before edge k+1.
- **Offset update timing.** A bitslip rising edge sampled at edge k changes slip_offset at edge k.
  - The output loaded at edge k still uses the old offset.
  - The output loaded at edge k+1 uses the new offset.
- **Injection timing.** err_inject sampled at edge k affects only the output loaded at edge k. It is a single-cycle flip.
- **Simultaneous events.** Bitslip, err_inject and link_up changes in the same cycle are all processed per the rules above with no priority conflict.
- **Link transitions.**
  - link_up falling: the invalid output appears after the same edge.
  - link_up rising: valid data resumes at the next edge, sourced from the window.
- **Reset mid-operation.**
  - Asserting reset discards in-flight blocks and the offset.
  - After deassertion, the first output edge at offset 0 shows cur_q=0 (reset value). Real data follows at latency 2.

## Test plan
1. **Basic loopback.** Reset; INIT_SLIP=0; link_up=1; drive hdr=2'b01, data=64'h0123_4567_89AB_CDEF on every cycle → after 2 edges rx_hdr=2'b01 and rx_data=64'h0123_4567_89AB_CDEF; slip_offset=0; both counters 0.
2. **Single slip.** Constant hdr=2'b10, data=0; one 1-cycle bitslip pulse → slip_offset=1, bitslip_events=1; the next output is rx_hdr=2'b01, rx_data=0.
3. **Level-held and wrap-around.** Bitslip held high for 5 cycles → only +1. Then 66 separate pulses (1 high, 8 low) → slip_offset returns to its prior value; bitslip_events=67.
4. **Error injection.** hdr=2'b01, data=0, offset 0; err_inject with err_bit=2 → exactly one output block has rx_data=64'h1 and err_count=1. err_bit=0 → rx_hdr=2'b00 for one block. err_bit=70 → no flip and err_count unchanged.
5. **Link down.** link_up=0 for 10 cycles → rx_hdr=2'b00 and rx_data=0 on all of them, and err_inject is ignored. Restore link_up → the pattern resumes at the next edge.
6. **Reset mid-stream.** With slip_offset=17 and counters nonzero, assert rx_tb reset between clock edges → all outputs and counters are 0 and slip_offset=INIT_SLIP immediately. After release, the stream returns per test 1.
